// File: rtl/uart_rx_ctrl_if.sv
// Register bus between the CPU-side decoder (master) and uart_rx_ctrl (slave).
// Every strobe is answered by a one-cycle reg_ack with reg_rdata valid alongside it.
interface uart_rx_ctrl_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        output reg_wr, reg_rd, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_wr, reg_rd, reg_addr, reg_wdata,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: byte FIFO, register file, divisor scheduling, frame-error release, IRQ.
// Optional macro UART_RX_AUTO_FERR_RELEASE_EN: ERR_HOLD releases the receiver without software.
//
// state    | meaning
// ERR_IDLE | no frame error outstanding
// ERR_HOLD | receiver stuck in frame error, waiting for a release request
// ERR_REL  | rx_finish pulsed once, waiting for rx_frame_err to drop
module uart_rx_ctrl #(
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [31:0] DEFAULT_CLK_DIV = 32'd434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_irq_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_frame_err_i,
    input  logic              rx_busy_i,
    output logic              rx_finish_o,
    output logic [31:0]       clk_div_o,
    output logic              irq_out_o,
    uart_rx_ctrl_if.slave     bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_DIV    = 2'd3;

    typedef enum logic [1:0] {ERR_IDLE, ERR_HOLD, ERR_REL} err_state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          rx_irq_q;
    logic          ovr_q, ferr_q;
    logic          data_en_q, err_en_q;
    logic [3:0]    thr_q;
    logic [31:0]   clk_div_q, pend_div_q;
    logic          pend_q;
    logic          ack_q;
    logic [31:0]   rdata_q;
    logic          irq_q;
    err_state_t    err_q, err_d;
    logic          fin_done_q;

    logic          wr_s, rd_s, empty, full, push, pop, push_ok, ovr_set;
    logic          status_wr, div_wr, ferr_set;
    logic [31:0]   div_wval, status_w, rd_val;
    logic [4:0]    count5;
    logic [3:0]    thr_eff;
    logic          irq_d;

    // A simultaneous write and read is treated as a write only.
    assign wr_s      = bus.reg_wr;
    assign rd_s      = bus.reg_rd & ~bus.reg_wr;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign push      = rx_irq_i & ~rx_irq_q;
    assign pop       = rd_s & (bus.reg_addr == A_DATA) & ~empty;
    assign push_ok   = push & (~full | pop);
    assign ovr_set   = push & full & ~pop;
    assign status_wr = wr_s & (bus.reg_addr == A_STATUS);
    assign div_wr    = wr_s & (bus.reg_addr == A_DIV);
    assign div_wval  = (bus.reg_wdata < 32'd2) ? 32'd2 : bus.reg_wdata;

    assign count5  = 5'(count_q);
    assign thr_eff = (thr_q == 4'd0) ? 4'd1 : thr_q;
    assign irq_d   = (data_en_q & (count5 >= {1'b0, thr_eff})) | (err_en_q & (ovr_q | ferr_q));

    always_comb begin
        status_w            = '0;
        status_w[0]         = empty;
        status_w[1]         = full;
        status_w[2]         = ovr_q;
        status_w[3]         = ferr_q;
        status_w[4]         = rx_busy_i;
        status_w[5]         = pend_q;
        status_w[8 +: CW]   = count_q;
        rd_val              = '0;
        unique case (bus.reg_addr)
            A_DATA:   rd_val = empty ? 32'd0 : {23'd0, 1'b1, mem_q[rptr_q]};
            A_STATUS: rd_val = status_w;
            A_CTRL:   rd_val = {24'd0, thr_q, 2'b00, err_en_q, data_en_q};
            A_DIV:    rd_val = clk_div_q;
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        err_d       = err_q;
        ferr_set    = 1'b0;
        rx_finish_o = 1'b0;
        unique case (err_q)
            ERR_IDLE: begin
                if (rx_frame_err_i) begin
                    ferr_set = 1'b1;
                    err_d    = ERR_HOLD;
                end
            end
            ERR_HOLD: begin
`ifdef UART_RX_AUTO_FERR_RELEASE_EN
                err_d = ERR_REL;
`else
                if (status_wr && bus.reg_wdata[3]) err_d = ERR_REL;
`endif
            end
            ERR_REL: begin
                rx_finish_o = ~fin_done_q;
                if (fin_done_q && !rx_frame_err_i) err_d = ERR_IDLE;
            end
            default: err_d = ERR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= ERR_IDLE;
            fin_done_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            fin_done_q <= (err_q == ERR_REL) & (err_d == ERR_REL);
        end
    end

    // Storage is not reset; empty/full are derived from count_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= rx_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_irq_q   <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            data_en_q  <= 1'b0;
            err_en_q   <= 1'b0;
            thr_q      <= 4'd0;
            clk_div_q  <= DEFAULT_CLK_DIV;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            rx_irq_q <= rx_irq_i;
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (!push_ok && pop) count_q <= count_q - CW'(1);

            // A new event wins over a software clear in the same cycle.
            if (ovr_set)                              ovr_q <= 1'b1;
            else if (status_wr && bus.reg_wdata[2])   ovr_q <= 1'b0;
            if (ferr_set)                             ferr_q <= 1'b1;
            else if (status_wr && bus.reg_wdata[3])   ferr_q <= 1'b0;

            if (wr_s && bus.reg_addr == A_CTRL) begin
                data_en_q <= bus.reg_wdata[0];
                err_en_q  <= bus.reg_wdata[1];
                thr_q     <= bus.reg_wdata[7:4];
            end

            if (div_wr) begin
                if (rx_busy_i) begin
                    pend_q     <= 1'b1;
                    pend_div_q <= div_wval;
                end else begin
                    clk_div_q <= div_wval;
                    pend_q    <= 1'b0;
                end
            end else if (pend_q && !rx_busy_i) begin
                clk_div_q <= pend_div_q;
                pend_q    <= 1'b0;
            end

            ack_q   <= wr_s | rd_s;
            rdata_q <= rd_s ? rd_val : 32'd0;
            irq_q   <= irq_d;
        end
    end

    assign clk_div_o     = clk_div_q;
    assign irq_out_o     = irq_q;
    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboarded bench for uart_rx_ctrl: reads queue their expected data, a monitor checks each ack.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_irq = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_frame_err = 1'b0;
    logic        rx_busy = 1'b0;
    logic        rx_finish;
    logic [31:0] clk_div;
    logic        irq_out;

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DEFAULT_CLK_DIV(32'd434)) dut (
        .clk(clk), .rst_n(rst_n), .rx_irq_i(rx_irq), .rx_data_i(rx_data),
        .rx_frame_err_i(rx_frame_err), .rx_busy_i(rx_busy), .rx_finish_o(rx_finish),
        .clk_div_o(clk_div), .irq_out_o(irq_out), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fin_cnt = 0;
    int fin_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        int          cyc;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    // Reference model
    logic [7:0]  fifo_m[$];
    bit          ovr_m, ferr_m, den_m, een_m, pend_m;
    int          thr_m;
    logic [31:0] div_m, pval_m;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rx_finish) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.reg_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_ack_latency"}, cyc, e.cyc + 1);
                if (e.chk) check(e.name, bus.reg_rdata, e.val);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        fifo_m.delete();
        ovr_m = 0; ferr_m = 0; den_m = 0; een_m = 0; pend_m = 0;
        thr_m = 0; div_m = 32'd434; pval_m = 32'd0;
    endtask

    function automatic logic [31:0] status_exp();
        return {19'd0, 5'(fifo_m.size()), 2'b00, pend_m, rx_busy, ferr_m, ovr_m,
                fifo_m.size() == DEPTH, fifo_m.size() == 0};
    endfunction

    task automatic rd(input logic [1:0] a, input string nm);
        logic [31:0] e;
        case (a)
            2'd0: e = (fifo_m.size() > 0) ? {23'd0, 1'b1, fifo_m.pop_front()} : 32'd0;
            2'd1: e = status_exp();
            2'd2: e = {24'd0, 4'(thr_m), 2'b00, een_m, den_m};
            default: e = div_m;
        endcase
        bus.reg_rd = 1'b1;
        bus.reg_addr = a;
        exp_q.push_back('{1'b1, e, cyc, nm});
        tick();
        bus.reg_rd = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] v;
        bus.reg_wr = 1'b1;
        bus.reg_addr = a;
        bus.reg_wdata = d;
        exp_q.push_back('{1'b0, 32'd0, cyc, "write"});
        case (a)
            2'd1: begin
                if (d[2]) ovr_m = 0;
                if (d[3]) ferr_m = 0;
            end
            2'd2: begin
                den_m = d[0]; een_m = d[1]; thr_m = int'(d[7:4]);
            end
            2'd3: begin
                v = (d < 2) ? 32'd2 : d;
                if (rx_busy) begin pend_m = 1; pval_m = v; end
                else begin div_m = v; pend_m = 0; end
            end
            default: ;
        endcase
        tick();
        bus.reg_wr = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data = b;
        rx_irq = 1'b1;
        if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
        else ovr_m = 1;
        tick();
        rx_irq = 1'b0;
        tick();
    endtask

    task automatic push_and_read(input logic [7:0] b, input string nm);
        logic [31:0] e;
        e = (fifo_m.size() > 0) ? {23'd0, 1'b1, fifo_m.pop_front()} : 32'd0;
        fifo_m.push_back(b);
        rx_data = b;
        rx_irq = 1'b1;
        bus.reg_rd = 1'b1;
        bus.reg_addr = 2'd0;
        exp_q.push_back('{1'b1, e, cyc, nm});
        tick();
        rx_irq = 1'b0;
        bus.reg_rd = 1'b0;
        tick();
    endtask

    task automatic check_irq(input string nm);
        int t;
        bit e;
        t = (thr_m == 0) ? 1 : thr_m;
        e = (den_m && fifo_m.size() >= t) || (een_m && (ovr_m || ferr_m));
        check(nm, 32'(irq_out), 32'(e));
    endtask

    initial begin
        int fc, c0, op;
        logic [31:0] v;
        bus.reg_wr = 1'b0;
        bus.reg_rd = 1'b0;
        bus.reg_addr = 2'd0;
        bus.reg_wdata = 32'd0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_clk_div", clk_div, 32'd434);
        check("reset_irq", 32'(irq_out), 32'd0);
        check("reset_rx_finish", 32'(rx_finish), 32'd0);
        check("reset_ack", 32'(bus.reg_ack), 32'd0);
        check("reset_rdata", bus.reg_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        rd(2'd3, "rd_clk_div_reset");
        rd(2'd1, "rd_status_reset");
        tick();

        // Threshold interrupt
        wr(2'd2, 32'h21);
        push_byte(8'hA5);
        check_irq("irq_one_byte");
        push_byte(8'h3C);
        check_irq("irq_two_bytes");
        rd(2'd0, "rd_data_a5");
        rd(2'd0, "rd_data_3c");
        rd(2'd0, "rd_data_empty");
        tick(); tick();
        check_irq("irq_after_drain");
        wr(2'd2, 32'h0);

        // Overflow
        for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
        rd(2'd1, "rd_status_full_ovr");
        for (int i = 0; i < 8; i++) rd(2'd0, "rd_data_ovr_drain");
        wr(2'd1, 32'h4);
        rd(2'd1, "rd_status_ovr_clr");

        // Push and pop in the same cycle at full
        for (int i = 0; i < 8; i++) push_byte(8'(i * 7 + 3));
        push_and_read(8'hEE, "rd_data_push_pop_full");
        rd(2'd1, "rd_status_push_pop_full");
        for (int i = 0; i < 9; i++) rd(2'd0, "rd_data_after_push_pop");

        // Frame error handshake
        wr(2'd2, 32'h2);
        fc = fin_cnt;
        c0 = cyc;
        rx_frame_err = 1'b1;
        ferr_m = 1;
        repeat (5) tick();
        check_irq("irq_ferr");
`ifdef UART_RX_AUTO_FERR_RELEASE_EN
        check("auto_release_pulses", fin_cnt - fc, 1);
        check("auto_release_delay", fin_cyc - c0, 2);
        rd(2'd1, "rd_status_ferr_auto");
`else
        check("no_release_without_write", fin_cnt - fc, 0);
        rd(2'd1, "rd_status_ferr");
        c0 = cyc;
        wr(2'd1, 32'h8);
        repeat (5) tick();
        check("sw_release_pulses", fin_cnt - fc, 1);
        check("sw_release_delay", fin_cyc - c0, 1);
`endif
        rx_frame_err = 1'b0;
        tick(); tick();
        wr(2'd1, 32'h8);
        repeat (3) tick();
        check("no_pulse_in_idle", fin_cnt - fc, 1);
        fc = fin_cnt;
        rx_frame_err = 1'b1;
        ferr_m = 1;
        tick(); tick();
        rd(2'd1, "rd_status_ferr_again");
`ifndef UART_RX_AUTO_FERR_RELEASE_EN
        wr(2'd1, 32'h8);
`endif
        repeat (4) tick();
        check("second_release_pulses", fin_cnt - fc, 1);
        rx_frame_err = 1'b0;
        tick(); tick();
        wr(2'd1, 32'h8);
        tick();
        check_irq("irq_ferr_cleared");
        wr(2'd2, 32'h0);

        // Divisor scheduling
        rx_busy = 1'b1;
        wr(2'd3, 32'd100);
        tick();
        check("clk_div_held_busy", clk_div, div_m);
        rd(2'd1, "rd_status_div_pending");
        wr(2'd3, 32'd77);
        tick();
        check("clk_div_held_replace", clk_div, div_m);
        rx_busy = 1'b0;
        tick();
        if (pend_m) begin div_m = pval_m; pend_m = 0; end
        check("clk_div_applied", clk_div, div_m);
        rd(2'd3, "rd_clk_div_applied");
        wr(2'd3, 32'd0);
        check("clk_div_zero_forced", clk_div, div_m);
        wr(2'd3, 32'd50);
        wr(2'd3, 32'd1);
        check("clk_div_one_forced", clk_div, div_m);

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: push_byte(8'($urandom));
                3, 4:    rd(2'd0, "rnd_rd_data");
                5:       rd(2'd1, "rnd_rd_status");
                6: begin
                    v = {24'd0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(0, 3))};
                    wr(2'd2, v);
                end
                7:       wr(2'd1, 32'($urandom_range(0, 1)) << 2);
                8:       push_and_read(8'($urandom), "rnd_push_pop");
                default: begin
                    v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                    wr(2'd3, v);
                    check("rnd_clk_div", clk_div, div_m);
                end
            endcase
            tick();
            check_irq("rnd_irq");
            if (it % 40 == 39) rd(2'd2, "rnd_rd_ctrl");
        end

        // Asynchronous reset in the middle of activity
        wr(2'd2, 32'h11);
        push_byte(8'h55);
        push_byte(8'h66);
        rx_busy = 1'b1;
        wr(2'd3, 32'd999);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_clk_div", clk_div, 32'd434);
        check("midreset_irq", 32'(irq_out), 32'd0);
        check("midreset_ack", 32'(bus.reg_ack), 32'd0);
        rx_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("midreset_pending_dropped", clk_div, 32'd434);
        rd(2'd1, "rd_status_after_midreset");
        rd(2'd2, "rd_ctrl_after_midreset");

        repeat (3) tick();
        check("acks_outstanding", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
